// File: rtl/mem_page_ctrl_pkg.sv
// Shared definitions for the paged memory controller: widths, page numbers, state enum.
package mcDefs;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned PAGE_W    = 4;
    localparam int unsigned BURST_LEN = 4;

    localparam logic [PAGE_W-1:0] MEMPAGE0 = 4'h0;
    localparam logic [PAGE_W-1:0] MEMPAGE1 = 4'h1;
    localparam logic [PAGE_W-1:0] MEMPAGE2 = 4'h2;
    localparam logic [PAGE_W-1:0] MEMPAGE3 = 4'h3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        RDRAIN = 2'd3
    } mc_state_t;

    // Page number carried in the top nibble of an address word.
    function automatic logic [PAGE_W-1:0] page_of(input logic [DATA_W-1:0] a);
        return a[DATA_W-1 -: PAGE_W];
    endfunction

endpackage

// File: rtl/mem_page_ctrl_if.sv
// Multiplexed host address/data bus between a bus master and a page controller.
interface mem_page_ctrl_if;
    import mcDefs::*;

    logic              AddrValid;
    logic              rw;
    logic [DATA_W-1:0] AddrDataIn;
    logic [DATA_W-1:0] AddrDataOut;
    logic              AddrDataOE;

    modport master (
        output AddrValid, rw, AddrDataIn,
        input  AddrDataOut, AddrDataOE
    );

    modport slave (
        input  AddrValid, rw, AddrDataIn,
        output AddrDataOut, AddrDataOE
    );

endinterface

// File: rtl/mem_page_ctrl.sv
// Page-decoded burst controller: maps host bursts on one 4-bit page onto a 4K-word array.
module mem_page_ctrl
    import mcDefs::*;
#(
    parameter logic [PAGE_W-1:0] PAGE  = MEMPAGE1,
    parameter int unsigned       BURST = BURST_LEN
) (
    input  logic              clk,
    input  logic              resetH,
    input  logic              AddrValid,
    input  logic              rw,
    input  logic [DATA_W-1:0] AddrDataIn,
    output logic [DATA_W-1:0] AddrDataOut,
    output logic              AddrDataOE,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    output logic              memWE,
    output logic              memRE,
    input  logic [DATA_W-1:0] memRData
);

    localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    mc_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q,    we_d;
    logic              re_q,    re_d;
    logic              oe_q,    oe_d;
    logic              last_word;
    logic              hit;

    assign last_word = (cnt_q == CNT_W'(BURST - 1));
    assign hit       = AddrValid && (page_of(AddrDataIn) == PAGE);

    // Next-state, counter, address and strobe computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        // Read data returns one cycle after each read strobe.
        oe_d    = re_q;

        if (we_q) begin
            wdata_d = AddrDataIn;
        end
        if (oe_q) begin
            rdata_d = memRData;
        end

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    base_d = AddrDataIn[ADDR_W-1:0];
                    addr_d = AddrDataIn[ADDR_W-1:0];
                    cnt_d  = '0;
                    if (rw) begin
                        state_d = READ;
                        re_d    = 1'b1;
                    end else begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = CNT_W'(cnt_q + 1'b1);
                    addr_d = base_q + ADDR_W'(cnt_d);
                    we_d   = 1'b1;
                end
            end
            READ: begin
                if (last_word) begin
                    state_d = RDRAIN;
                end else begin
                    cnt_d  = CNT_W'(cnt_q + 1'b1);
                    addr_d = base_q + ADDR_W'(cnt_d);
                    re_d   = 1'b1;
                end
            end
            RDRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            oe_q    <= oe_d;
        end
    end

    // Data paths pass through while active and hold the last word otherwise.
    assign memAddr     = addr_q;
    assign memWE       = we_q;
    assign memRE       = re_q;
    assign memWData    = we_q ? AddrDataIn : wdata_q;
    assign AddrDataOE  = oe_q;
    assign AddrDataOut = oe_q ? memRData : rdata_q;

endmodule

// File: tb/tb_mem_page_ctrl.sv
// Directed bench for mem_page_ctrl on page 2 with a behavioural 4K x 16 array.
module tb_mem_page_ctrl;
    import mcDefs::*;

    logic        clk;
    logic        resetH;
    logic [11:0] memAddr;
    logic [15:0] memWData;
    logic        memWE;
    logic        memRE;
    logic [15:0] memRData;
    logic [15:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    mem_page_ctrl_if bus ();

    mem_page_ctrl #(.PAGE(MEMPAGE2), .BURST(4)) dut (
        .clk         (clk),
        .resetH      (resetH),
        .AddrValid   (bus.AddrValid),
        .rw          (bus.rw),
        .AddrDataIn  (bus.AddrDataIn),
        .AddrDataOut (bus.AddrDataOut),
        .AddrDataOE  (bus.AddrDataOE),
        .memAddr     (memAddr),
        .memWData    (memWData),
        .memWE       (memWE),
        .memRE       (memRE),
        .memRData    (memRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous array with one-cycle read latency.
    always @(posedge clk) begin
        if (memWE) mem[memAddr] <= memWData;
        if (memRE) memRData <= mem[memAddr];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a,
                            input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3,
                            input bit inject, input bit rel_rst);
        logic [15:0] d [4];
        logic [11:0] base;
        d    = '{d0, d1, d2, d3};
        base = a[11:0];
        @(posedge clk); #1;
        bus.AddrValid  = 1'b1;
        bus.rw         = 1'b0;
        bus.AddrDataIn = a;
        if (rel_rst) resetH = 1'b0;
        #1;
        chk("wr_addr_cycle_we", 16'(memWE), 16'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.AddrValid  = inject;
            bus.AddrDataIn = d[i];
            #1;
            chk("wr_we",    16'(memWE), 16'd1);
            chk("wr_re",    16'(memRE), 16'd0);
            chk("wr_addr",  16'(memAddr), 16'(12'(base + 12'(i))));
            chk("wr_data",  memWData, d[i]);
            chk("wr_oe",    16'(bus.AddrDataOE), 16'd0);
        end
    endtask

    task automatic do_read(input logic [15:0] a,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input bit inject);
        logic [15:0] e [4];
        logic [11:0] base;
        e    = '{e0, e1, e2, e3};
        base = a[11:0];
        @(posedge clk); #1;
        bus.AddrValid  = 1'b1;
        bus.rw         = 1'b1;
        bus.AddrDataIn = a;
        #1;
        chk("rd_addr_cycle_re", 16'(memRE), 16'd0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.AddrValid  = inject;
            bus.rw         = 1'b0;
            bus.AddrDataIn = 16'h2100;
            #1;
            chk("rd_re", 16'(memRE), (c <= 4) ? 16'd1 : 16'd0);
            chk("rd_we", 16'(memWE), 16'd0);
            chk("rd_oe", 16'(bus.AddrDataOE), (c >= 2) ? 16'd1 : 16'd0);
            if (c <= 4) chk("rd_addr", 16'(memAddr), 16'(12'(base + 12'(c - 1))));
            if (c >= 2) chk("rd_data", bus.AddrDataOut, e[c-2]);
        end
    endtask

    initial begin
        resetH         = 1'b1;
        bus.AddrValid  = 1'b0;
        bus.rw         = 1'b0;
        bus.AddrDataIn = 16'h0000;

        // Reset values.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_we",   16'(memWE), 16'd0);
        chk("rst_re",   16'(memRE), 16'd0);
        chk("rst_oe",   16'(bus.AddrDataOE), 16'd0);
        chk("rst_dout", bus.AddrDataOut, 16'h0000);
        chk("rst_addr", 16'(memAddr), 16'h0000);
        chk("rst_wdat", memWData, 16'h0000);

        // First hit right after reset release; page-2 data words must not restart.
        do_write(16'h2010, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 1'b1);
        @(posedge clk); #1;
        bus.AddrValid  = 1'b0;
        bus.AddrDataIn = 16'h0000;
        #1;
        chk("wr_idle_we",    16'(memWE), 16'd0);
        chk("wr_hold_addr",  16'(memAddr), 16'h0013);
        chk("wr_hold_wdata", memWData, 16'h4444);
        chk("mem_010", mem[12'h010], 16'h1111);
        chk("mem_013", mem[12'h013], 16'h4444);

        // Preload, back-to-back writes.
        do_write(16'h2010, 16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, 1'b0, 1'b0);
        do_write(16'h2000, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b0, 1'b0);

        // Read with ignored AddrValid, then a back-to-back read.
        do_read(16'h2010, 16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, 1'b1);
        do_read(16'h2000, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b0);
        @(posedge clk); #1;
        bus.AddrValid = 1'b0;
        #1;
        chk("rd_idle_oe",   16'(bus.AddrDataOE), 16'd0);
        chk("rd_hold_dout", bus.AddrDataOut, 16'hDEF0);
        chk("rd_hold_addr", 16'(memAddr), 16'h0003);

        // Page miss with both rw values.
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus.AddrValid  = (c < 2);
            bus.rw         = (c == 1);
            bus.AddrDataIn = 16'h3010;
            #1;
            chk("miss_we",   16'(memWE), 16'd0);
            chk("miss_re",   16'(memRE), 16'd0);
            chk("miss_oe",   16'(bus.AddrDataOE), 16'd0);
            chk("miss_addr", 16'(memAddr), 16'h0003);
        end

        // Address wrap at the top of the array.
        do_write(16'h2FFE, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.AddrValid = 1'b0;
        #1;
        chk("wrap_ffe", mem[12'hFFE], 16'h5555);
        chk("wrap_fff", mem[12'hFFF], 16'h6666);
        chk("wrap_000", mem[12'h000], 16'h7777);
        chk("wrap_001", mem[12'h001], 16'h8888);

        // Reset in the middle of a read burst.
        @(posedge clk); #1;
        bus.AddrValid  = 1'b1;
        bus.rw         = 1'b1;
        bus.AddrDataIn = 16'h2010;
        repeat (3) begin
            @(posedge clk); #1;
            bus.AddrValid = 1'b0;
        end
        #1;
        chk("rr_pre_oe",   16'(bus.AddrDataOE), 16'd1);
        chk("rr_pre_dout", bus.AddrDataOut, 16'hB1B1);
        resetH = 1'b1;
        #1;
        chk("rr_oe",   16'(bus.AddrDataOE), 16'd0);
        chk("rr_dout", bus.AddrDataOut, 16'h0000);
        chk("rr_re",   16'(memRE), 16'd0);
        chk("rr_addr", 16'(memAddr), 16'h0000);
        @(posedge clk); #1;
        resetH = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("rr_after_re", 16'(memRE), 16'd0);
            chk("rr_after_we", 16'(memWE), 16'd0);
            chk("rr_after_oe", 16'(bus.AddrDataOE), 16'd0);
        end
        do_read(16'h2000, 16'h7777, 16'h8888, 16'h9ABC, 16'hDEF0, 1'b0);

        @(posedge clk); #1;
        bus.AddrValid = 1'b0;
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_page_ctrl.md
MEM_PAGE_CTRL -- requirements
Module: mem_page_ctrl

Interface
REQ-001 SHALL have parameter PAGE, default MEMPAGE1, meaning the 4-bit page number this controller answers to.
REQ-002 SHALL have parameter BURST, default 4, meaning the words per bus transaction.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetH, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port AddrValid, input, 1 bit: the master presents an address on AddrDataIn this cycle.
REQ-006 SHALL have port rw, input, 1 bit: 1 = read, 0 = write; sampled with AddrValid.
REQ-007 SHALL have port AddrDataIn, input, 16 bits: multiplexed address/write data from the master.
REQ-008 SHALL have port AddrDataOut, output, 16 bits: read data toward the master.
REQ-009 SHALL have port AddrDataOE, output, 1 bit: AddrDataOut valid and driven onto the bus.
REQ-010 SHALL have port memAddr, output, 12 bits: word address into the memory array.
REQ-011 SHALL have port memWData, output, 16 bits: write data to the array.
REQ-012 SHALL have port memWE, output, 1 bit: array write strobe.
REQ-013 SHALL have port memRE, output, 1 bit: array read strobe.
REQ-014 SHALL have port memRData, input, 16 bits: array read data, valid one cycle after memRE.

Function
REQ-015 SHALL implement the FSM states IDLE, WRITE, READ and RDRAIN.
REQ-016 In IDLE, SHALL treat AddrValid=1 with AddrDataIn[15:12]==PAGE as a hit: latch AddrDataIn[11:0] as base and clear the word counter.
REQ-017 On a hit, SHALL go to READ if rw=1 and to WRITE if rw=0.
REQ-018 In IDLE, SHALL ignore AddrValid with any other page and change no state or outputs.
REQ-019 In WRITE, on cycles T+1..T+BURST (T = address cycle), SHALL drive memWE=1, memAddr=base+i and memWData=AddrDataIn, with i=0..BURST-1.
REQ-020 After the last write word, SHALL return to IDLE.
REQ-021 In READ, on cycles T+1..T+BURST, SHALL assert memRE=1 with memAddr=base+i.
REQ-022 SHALL drive AddrDataOut=memRData with AddrDataOE=1 on cycles T+2..T+BURST+1, registered from the one-cycle array latency.
REQ-023 SHALL use RDRAIN to cover the final output cycle, then return to IDLE.
REQ-024 SHALL compute addresses modulo 2^12, so base 12'hFFE wraps to FFE, FFF, 000, 001.
REQ-025 SHALL ignore AddrValid while not in IDLE.
REQ-026 A new hit SHALL be accepted no earlier than the cycle after the return to IDLE.
REQ-027 SHALL never assert memWE and memRE in the same cycle.
REQ-028 SHALL keep AddrDataOE=0 in IDLE and WRITE.
REQ-029 Outside active cycles, SHALL hold memAddr, memWData and AddrDataOut at their last value.

Reset
REQ-030 Asserting resetH SHALL immediately force state IDLE, counter 0, base 0, memWE=0, memRE=0, AddrDataOE=0, AddrDataOut=0, memAddr=0 and memWData=0.
REQ-031 Reset mid-burst SHALL abort the burst: no further array strobes, and the remaining words are discarded.
REQ-032 The first hit SHALL be accepted on the first rising edge after resetH deasserts.

Structure
REQ-033 The shared package mcDefs SHALL hold the page constants (MEMPAGE1 etc.), BURST_LEN and the controller state enum.
REQ-034 SHALL be built as a single module with no sub-module; the word counter and address adder SHALL stay inline.

Verification
REQ-035 Write burst: PAGE=2, addr 16'h2010, rw=0, data 1111/2222/3333/4444 -> memWE on 4 cycles at 010..013 with matching data, then IDLE.
REQ-036 Read burst: array preloaded 010..013 = A0A0/B1B1/C2C2/D3D3, addr 16'h2010, rw=1 -> AddrDataOE high on T+2..T+5 with that data in order.
REQ-037 Page miss: addr 16'h3010 with AddrValid, both rw values -> no memWE/memRE/AddrDataOE ever asserted.
REQ-038 Wrap: write addr 16'h2FFE -> memAddr FFE, FFF, 000, 001.
REQ-039 Reset mid-read: resetH pulsed at T+3 -> AddrDataOE=0 immediately and no strobes afterward; then a new read at 16'h2000 completes normally.
REQ-040 Back-to-back: AddrValid asserted during a burst is ignored, and a hit on the cycle after the return to IDLE is served with the correct 4-word response.
